// File: rtl/snitch_asic_dw_converter.sv
// ASIC-side data-width converter: serialises 32b core writes into narrow link beats and
// reassembles MSB-first read beats. Optional sticky framing error via SNITCH_DW_LAST_CHECK_EN.
module snitch_asic_dw_converter #(
    parameter  int unsigned AsicAW    = 8,
    parameter  int unsigned AsicDW    = 4,
    parameter  int unsigned MemDW     = 32,
    localparam int unsigned Stages    = MemDW / AsicDW,
    localparam int unsigned StrbWidth = MemDW / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AsicAW-1:0]    core_req_addr_i,
    input  logic [MemDW-1:0]     core_req_data_i,
    input  logic                 core_req_write_i,
    input  logic [StrbWidth-1:0] core_req_wstrb_i,
    input  logic                 core_req_valid_i,
    output logic                 core_req_ready_o,
    output logic [MemDW-1:0]     core_rsp_data_o,
    output logic                 core_rsp_valid_o,
    input  logic                 core_rsp_ready_i,
    output logic [AsicAW-1:0]    fpga_req_addr_o,
    output logic [AsicDW-1:0]    fpga_req_data_o,
    output logic                 fpga_req_write_o,
    output logic                 fpga_req_wstrb_o,
    output logic                 fpga_req_valid_o,
    input  logic                 fpga_req_ready_i,
    input  logic [AsicDW-1:0]    fpga_rsp_data_i,
    input  logic                 fpga_rsp_last_i,
    input  logic                 fpga_rsp_valid_i,
    output logic                 fpga_rsp_ready_o
`ifdef SNITCH_DW_LAST_CHECK_EN
    ,
    output logic                 err_o
`endif
);

    localparam int unsigned     CntW     = (Stages > 1) ? $clog2(Stages) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(Stages - 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WR_SER     = 3'd1;
    localparam logic [2:0] RD_REQ     = 3'd2;
    localparam logic [2:0] RD_COLLECT = 3'd3;
    localparam logic [2:0] RSP        = 3'd4;

    logic [2:0]           state_reg, state_next;
    logic [CntW-1:0]      cnt_reg, cnt_next;
    logic [AsicAW-1:0]    addr_reg, addr_next;
    logic [MemDW-1:0]     wdata_reg, wdata_next;
    logic [StrbWidth-1:0] wstrb_reg, wstrb_next;
    logic [MemDW-1:0]     shift_reg, shift_next;

    logic [AsicDW-1:0] beat_data [Stages];
    logic [Stages-1:0] beat_strb;

    // Beat gi carries the gi-th nibble from the top; its strobe is that of the enclosing byte.
    for (genvar gi = 0; gi < Stages; gi++) begin : g_beat
        localparam int unsigned Msb = MemDW - 1 - gi * AsicDW;
        assign beat_data[gi] = wdata_reg[Msb -: AsicDW];
        assign beat_strb[gi] = wstrb_reg[Msb / 8];
    end

    assign core_req_ready_o = (state_reg == IDLE);
    assign fpga_req_valid_o = (state_reg == WR_SER) || (state_reg == RD_REQ);
    assign fpga_req_write_o = (state_reg == WR_SER);
    assign fpga_req_addr_o  = fpga_req_valid_o ? addr_reg : '0;
    assign fpga_req_data_o  = (state_reg == WR_SER) ? beat_data[cnt_reg] : '0;
    assign fpga_req_wstrb_o = (state_reg == WR_SER) ? beat_strb[cnt_reg] : 1'b0;
    assign fpga_rsp_ready_o = (state_reg == RD_COLLECT);
    assign core_rsp_valid_o = (state_reg == RSP);
    assign core_rsp_data_o  = (state_reg == RSP) ? shift_reg : '0;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        wstrb_next = wstrb_reg;
        shift_next = shift_reg;
        case (state_reg)
            IDLE: begin
                if (core_req_valid_i) begin
                    addr_next  = core_req_addr_i;
                    wdata_next = core_req_data_i;
                    wstrb_next = core_req_wstrb_i;
                    cnt_next   = '0;
                    state_next = core_req_write_i ? WR_SER : RD_REQ;
                end
            end
            WR_SER: begin
                if (fpga_req_ready_i) begin
                    if (cnt_reg == LastBeat) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (fpga_req_ready_i) begin
                    state_next = RD_COLLECT;
                end
            end
            RD_COLLECT: begin
                // Collection ends on the beat count alone; the last flag only feeds the checker.
                if (fpga_rsp_valid_i) begin
                    shift_next = {shift_reg[MemDW-AsicDW-1:0], fpga_rsp_data_i};
                    if (cnt_reg == LastBeat) begin
                        cnt_next   = '0;
                        state_next = RSP;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            RSP: begin
                if (core_rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            wstrb_reg <= wstrb_next;
            shift_reg <= shift_next;
        end
    end

`ifdef SNITCH_DW_LAST_CHECK_EN
    logic err_reg, err_next;

    always_comb begin
        err_next = err_reg;
        if (fpga_rsp_valid_i && (state_reg != RD_COLLECT)) begin
            err_next = 1'b1;
        end
        if (fpga_rsp_valid_i && fpga_rsp_ready_o && (fpga_rsp_last_i != (cnt_reg == LastBeat))) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign err_o = err_reg;
`else
    logic unused_rsp_last;
    assign unused_rsp_last = fpga_rsp_last_i;
`endif

endmodule

// File: tb/tb_snitch_asic_dw_converter.sv
// Bench for snitch_asic_dw_converter: cycle-exact vector table, randomized stalls against a
// word/nibble reference model, asynchronous reset abort and response-framing corner case.
module tb_snitch_asic_dw_converter;

    localparam int AW = 8;
    localparam int DW = 4;
    localparam int MW = 32;
    localparam int ST = MW / DW;
    localparam int SW = MW / 8;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [MW-1:0] data;       // write data, or the word the link returns for a read
        logic [SW-1:0] wstrb;
        logic [ST-1:0] exp_strb;   // bit ST-1 belongs to beat 0
        logic [ST-1:0] last_mask;  // bit ST-1 belongs to beat 0
        logic [MW-1:0] exp_word;   // expected beat stream (write) or core data (read)
    } vec_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [AW-1:0] core_req_addr_i;
    logic [MW-1:0] core_req_data_i;
    logic          core_req_write_i;
    logic [SW-1:0] core_req_wstrb_i;
    logic          core_req_valid_i;
    logic          core_req_ready_o;
    logic [MW-1:0] core_rsp_data_o;
    logic          core_rsp_valid_o;
    logic          core_rsp_ready_i;
    logic [AW-1:0] fpga_req_addr_o;
    logic [DW-1:0] fpga_req_data_o;
    logic          fpga_req_write_o;
    logic          fpga_req_wstrb_o;
    logic          fpga_req_valid_o;
    logic          fpga_req_ready_i;
    logic [DW-1:0] fpga_rsp_data_i;
    logic          fpga_rsp_last_i;
    logic          fpga_rsp_valid_i;
    logic          fpga_rsp_ready_o;
`ifdef SNITCH_DW_LAST_CHECK_EN
    logic          err_o;
`endif

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [49:0] RST_OUTS = {1'b1, 49'd0};

    snitch_asic_dw_converter dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .core_req_addr_i  (core_req_addr_i),
        .core_req_data_i  (core_req_data_i),
        .core_req_write_i (core_req_write_i),
        .core_req_wstrb_i (core_req_wstrb_i),
        .core_req_valid_i (core_req_valid_i),
        .core_req_ready_o (core_req_ready_o),
        .core_rsp_data_o  (core_rsp_data_o),
        .core_rsp_valid_o (core_rsp_valid_o),
        .core_rsp_ready_i (core_rsp_ready_i),
        .fpga_req_addr_o  (fpga_req_addr_o),
        .fpga_req_data_o  (fpga_req_data_o),
        .fpga_req_write_o (fpga_req_write_o),
        .fpga_req_wstrb_o (fpga_req_wstrb_o),
        .fpga_req_valid_o (fpga_req_valid_o),
        .fpga_req_ready_i (fpga_req_ready_i),
        .fpga_rsp_data_i  (fpga_rsp_data_i),
        .fpga_rsp_last_i  (fpga_rsp_last_i),
        .fpga_rsp_valid_i (fpga_rsp_valid_i),
        .fpga_rsp_ready_o (fpga_rsp_ready_o)
`ifdef SNITCH_DW_LAST_CHECK_EN
        ,
        .err_o            (err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // k-th link nibble of a word, counted from the most significant end.
    function automatic logic [DW-1:0] nib(input logic [MW-1:0] w, input int k);
        return DW'(w >> (MW - DW * (k + 1)));
    endfunction

    function automatic logic [49:0] outs();
        return {core_req_ready_o, fpga_req_valid_o, fpga_req_write_o, fpga_req_wstrb_o,
                core_rsp_valid_o, fpga_rsp_ready_o, fpga_req_addr_o, fpga_req_data_o,
                core_rsp_data_o};
    endfunction

    // Every task below is entered and left 1 time unit after a rising edge.
    task automatic run_vec(input vec_t v, input string tag);
        bit ok;
        core_req_valid_i = 1'b1;
        core_req_addr_i  = v.addr;
        core_req_data_i  = v.wr ? v.data : 32'h0BAD_F00D;
        core_req_write_i = v.wr;
        core_req_wstrb_i = v.wstrb;
        fpga_req_ready_i = 1'b1;
        core_rsp_ready_i = 1'b0;
        fpga_rsp_valid_i = 1'b0;
        fpga_rsp_last_i  = 1'b0;
        @(negedge clk_i);
        check({tag, "_accept"}, core_req_ready_o, 1'b1);
        @(posedge clk_i); #1;
        core_req_valid_i = 1'b0;
        if (v.wr) begin
            for (int k = 0; k < ST; k++) begin
                @(negedge clk_i);
                check($sformatf("%s_beat%0d", tag, k),
                      {fpga_req_valid_o, fpga_req_write_o, fpga_req_addr_o, fpga_req_data_o, fpga_req_wstrb_o},
                      {1'b1, 1'b1, v.addr, nib(v.exp_word, k), v.exp_strb[ST-1-k]});
            end
            @(negedge clk_i);
            check({tag, "_idle"}, {core_req_ready_o, fpga_req_valid_o}, 2'b10);
        end else begin
            @(negedge clk_i);
            check({tag, "_rdreq"},
                  {fpga_req_valid_o, fpga_req_write_o, fpga_req_addr_o, fpga_req_data_o, fpga_req_wstrb_o, fpga_rsp_ready_o},
                  {1'b1, 1'b0, v.addr, 4'h0, 1'b0, 1'b0});
            ok = 1'b1;
            for (int k = 0; k < ST; k++) begin
                @(posedge clk_i); #1;
                fpga_rsp_valid_i = 1'b1;
                fpga_rsp_data_i  = nib(v.data, k);
                fpga_rsp_last_i  = v.last_mask[ST-1-k];
                @(negedge clk_i);
                if (!fpga_rsp_ready_o || core_rsp_valid_o) ok = 1'b0;
            end
            @(posedge clk_i); #1;
            fpga_rsp_valid_i = 1'b0;
            fpga_rsp_last_i  = 1'b0;
            fpga_rsp_data_i  = '0;
            check({tag, "_collect"}, ok, 1'b1);
            for (int h = 0; h < 3; h++) begin
                @(negedge clk_i);
                check($sformatf("%s_hold%0d", tag, h),
                      {core_rsp_valid_o, core_rsp_data_o, fpga_rsp_ready_o, core_req_ready_o},
                      {1'b1, v.exp_word, 1'b0, 1'b0});
            end
            @(posedge clk_i); #1;
            core_rsp_ready_i = 1'b1;
            @(negedge clk_i);
            check({tag, "_rsp"}, {core_rsp_valid_o, core_rsp_data_o}, {1'b1, v.exp_word});
            @(posedge clk_i); #1;
            core_rsp_ready_i = 1'b0;
            @(negedge clk_i);
            check({tag, "_rspdone"}, {core_rsp_valid_o, core_rsp_data_o, core_req_ready_o}, {1'b0, 32'h0, 1'b1});
        end
        @(posedge clk_i); #1;
    endtask

    task automatic rand_txn(input int t);
        bit            wr, ok, got_hs, done, idle_ok;
        logic [AW-1:0] a;
        logic [MW-1:0] d, act_word, got;
        logic [SW-1:0] s;
        logic [ST-1:0] exp_strb, act_strb;
        int            cnt, cyc, idx;
        wr = ($urandom_range(0, 1) == 1);
        a  = AW'($urandom);
        d  = $urandom;
        s  = SW'($urandom);
        for (int k = 0; k < ST; k++) exp_strb[ST-1-k] = s[SW-1-(k*DW)/8];

        core_req_valid_i = 1'b1;
        core_req_addr_i  = a;
        core_req_data_i  = d;
        core_req_write_i = wr;
        core_req_wstrb_i = s;
        got_hs = 1'b0;
        cyc    = 0;
        while (!got_hs && cyc < 50) begin
            fpga_req_ready_i = ($urandom_range(0, 1) == 1);
            @(negedge clk_i);
            got_hs = core_req_ready_o;
            @(posedge clk_i); #1;
            cyc++;
        end
        core_req_valid_i = 1'b0;

        ok  = 1'b1;
        cyc = 0;
        if (wr) begin
            cnt      = 0;
            act_word = '0;
            act_strb = '0;
            while (cnt < ST && cyc < 200) begin
                fpga_req_ready_i = ($urandom_range(0, 1) == 1);
                fpga_rsp_valid_i = ($urandom_range(0, 1) == 1);
                fpga_rsp_data_i  = DW'($urandom);
                @(negedge clk_i);
                if (fpga_rsp_ready_o) ok = 1'b0;
                if (fpga_req_valid_o && fpga_req_ready_i) begin
                    if (!fpga_req_write_o || fpga_req_addr_o !== a) ok = 1'b0;
                    act_word = {act_word[MW-DW-1:0], fpga_req_data_o};
                    act_strb = {act_strb[ST-2:0], fpga_req_wstrb_o};
                    cnt++;
                end
                @(posedge clk_i); #1;
                cyc++;
            end
            fpga_rsp_valid_i = 1'b0;
            @(negedge clk_i);
            idle_ok = core_req_ready_o && !fpga_req_valid_o;
            @(posedge clk_i); #1;
            check($sformatf("rnd_wr%0d", t), {got_hs, cnt[7:0], act_word, act_strb, ok, idle_ok},
                  {1'b1, 8'(ST), d, exp_strb, 1'b1, 1'b1});
        end else begin
            got_hs = 1'b0;
            while (!got_hs && cyc < 200) begin
                fpga_req_ready_i = ($urandom_range(0, 1) == 1);
                fpga_rsp_valid_i = ($urandom_range(0, 1) == 1);
                fpga_rsp_data_i  = nib(d, 0);
                fpga_rsp_last_i  = 1'b0;
                @(negedge clk_i);
                if (fpga_rsp_ready_o) ok = 1'b0;
                if (fpga_req_valid_o && fpga_req_ready_i) begin
                    got_hs = 1'b1;
                    if (fpga_req_write_o || fpga_req_addr_o !== a || fpga_req_data_o !== '0 || fpga_req_wstrb_o) ok = 1'b0;
                end
                @(posedge clk_i); #1;
                cyc++;
            end
            fpga_req_ready_i = 1'b0;
            idx = 0;
            while (idx < ST && cyc < 400) begin
                fpga_rsp_valid_i = ($urandom_range(0, 1) == 1);
                fpga_rsp_data_i  = nib(d, idx);
                fpga_rsp_last_i  = (idx == ST - 1);
                @(negedge clk_i);
                if (fpga_req_valid_o) ok = 1'b0;
                if (fpga_rsp_valid_i && fpga_rsp_ready_o) idx++;
                @(posedge clk_i); #1;
                cyc++;
            end
            done = 1'b0;
            got  = '0;
            while (!done && cyc < 600) begin
                core_rsp_ready_i = ($urandom_range(0, 1) == 1);
                fpga_rsp_valid_i = ($urandom_range(0, 1) == 1);
                fpga_rsp_data_i  = DW'($urandom);
                fpga_rsp_last_i  = 1'b0;
                @(negedge clk_i);
                if (fpga_rsp_ready_o) ok = 1'b0;
                if (core_rsp_valid_o) begin
                    if (core_rsp_data_o !== d) ok = 1'b0;
                    if (core_rsp_ready_i) begin
                        done = 1'b1;
                        got  = core_rsp_data_o;
                    end
                end
                @(posedge clk_i); #1;
                cyc++;
            end
            core_rsp_ready_i = 1'b0;
            fpga_rsp_valid_i = 1'b0;
            check($sformatf("rnd_rd%0d", t), {got_hs, idx[7:0], got, ok, done},
                  {1'b1, 8'(ST), d, 1'b1, 1'b1});
        end
    endtask

    initial begin
        vec_t vecs [6];
        vec_t v;
        vecs[0] = '{1'b1, 8'h12, 32'hDEADBEEF, 4'b1111, 8'b1111_1111, 8'h00, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 8'h34, 32'h11223344, 4'b0100, 8'b0011_0000, 8'h00, 32'h11223344};
        vecs[2] = '{1'b0, 8'h05, 32'hCAFEBABE, 4'b0000, 8'h00, 8'h01, 32'hCAFEBABE};
        vecs[3] = '{1'b1, 8'hA7, 32'hA5A55A5A, 4'b1001, 8'b1100_0011, 8'h00, 32'hA5A55A5A};
        vecs[4] = '{1'b0, 8'hFF, 32'h01234567, 4'b0000, 8'h00, 8'h01, 32'h01234567};
        vecs[5] = '{1'b1, 8'h00, 32'hFFFFFFFF, 4'b0000, 8'h00, 8'h00, 32'hFFFFFFFF};

        rst_ni           = 1'b0;
        core_req_addr_i  = '0;
        core_req_data_i  = '0;
        core_req_write_i = 1'b0;
        core_req_wstrb_i = '0;
        core_req_valid_i = 1'b0;
        core_rsp_ready_i = 1'b0;
        fpga_req_ready_i = 1'b0;
        fpga_rsp_data_i  = '0;
        fpga_rsp_last_i  = 1'b0;
        fpga_rsp_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_state", outs(), RST_OUTS);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("post_reset_idle", outs(), RST_OUTS);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        for (int t = 0; t < 100; t++) begin
            rand_txn(t);
        end

        // Abort a write mid-burst with an asynchronous reset.
        core_req_valid_i = 1'b1;
        core_req_addr_i  = 8'h33;
        core_req_data_i  = 32'hDEADBEEF;
        core_req_write_i = 1'b1;
        core_req_wstrb_i = 4'b1111;
        fpga_req_ready_i = 1'b1;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        core_req_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        check("pre_reset_beat3", {fpga_req_valid_o, fpga_req_data_o}, {1'b1, 4'hD});
        rst_ni = 1'b0;
        #1;
        check("async_reset_outs", outs(), RST_OUTS);
        @(posedge clk_i); #1;
        check("held_reset_outs", outs(), RST_OUTS);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
`ifdef SNITCH_DW_LAST_CHECK_EN
        check("err_clear_after_reset", err_o, 1'b0);
`endif
        run_vec(vecs[2], "post_abort_rd");

        // Misplaced last flag on beat 4 (and missing on the final beat).
        v = '{1'b0, 8'h5A, 32'hCAFEBABE, 4'b0000, 8'h00, 8'b0000_1000, 32'hCAFEBABE};
`ifdef SNITCH_DW_LAST_CHECK_EN
        check("err_before_badlast", err_o, 1'b0);
`endif
        run_vec(v, "badlast");
`ifdef SNITCH_DW_LAST_CHECK_EN
        check("err_set", err_o, 1'b1);
        repeat (3) @(posedge clk_i);
        #1;
        check("err_sticky", err_o, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
